// File: rtl/bus_slave_sel_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bus_slave_sel_pkg
// Purpose  : Shared constants, FSM encoding and helpers for the slave selector.
// Revision : 1.0 - initial release
// ============================================================================
package bus_slave_sel_pkg;

   localparam logic c_enable_         = 1'b0;
   localparam logic c_disable_        = 1'b1;
   localparam int   c_bus_addr_width  = 16;

   typedef enum logic [1:0] {
      BSS_IDLE   = 2'd0,
      BSS_ACCESS = 2'd1,
      BSS_ERR    = 2'd2,
      BSS_DONE   = 2'd3
   } bss_state_e;

   // Never returns less than 1 so derived vectors stay legal for tiny values.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) begin
         r = r + 1;
      end
      return (r == 0) ? 1 : r;
   endfunction

endpackage : bus_slave_sel_pkg
`default_nettype wire

// File: rtl/bus_slave_sel_if.sv
`default_nettype none
// ============================================================================
// Module   : bus_slave_sel_if
// Purpose  : Master request / slave select signal bundle for bus_slave_sel.
// Revision : 1.0 - initial release
// ============================================================================
interface bus_slave_sel_if
   import bus_slave_sel_pkg::*;
#(
   parameter int ADDR_W = c_bus_addr_width,
   parameter int CH_NUM = 4
);
   logic              as_;
   logic [ADDR_W-1:0] addr;
   logic [CH_NUM-1:0] cs_;
   logic [CH_NUM-1:0] slv_rdy_;
   logic              rdy_;
   logic              bus_err;
   logic              busy;

   // Selector-side view: the decoder itself.
   modport slave (
      input  as_,
      input  addr,
      input  slv_rdy_,
      output cs_,
      output rdy_,
      output bus_err,
      output busy
   );

   // Environment-side view: bus master plus slave array.
   modport master (
      output as_,
      output addr,
      output slv_rdy_,
      input  cs_,
      input  rdy_,
      input  bus_err,
      input  busy
   );

endinterface : bus_slave_sel_if
`default_nettype wire

// File: rtl/bus_slave_sel_wait_timer.sv
`default_nettype none
// ============================================================================
// Module   : bus_wait_timer
// Purpose  : Saturating wait-cycle counter; flags when TIMEOUT-1 is reached.
// Revision : 1.0 - initial release
// ============================================================================
module bus_wait_timer
   import bus_slave_sel_pkg::*;
#(
   parameter int TIMEOUT = 16
) (
   input  wire  clk,
   input  wire  reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int             CNT_W  = clog2(TIMEOUT);
   localparam logic [CNT_W-1:0] c_last = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // Holds at the last value so a late ready can never see a wrapped count.
   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (enable && (count_q != c_last)) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign expired = (count_q == c_last);

endmodule : bus_wait_timer
`default_nettype wire

// File: rtl/bus_slave_sel.sv
`default_nettype none
// ============================================================================
// Module   : bus_slave_sel
// Purpose  : Registered chip-select decoder with ready return and bus timeout.
// Revision : 1.0 - initial release
// ============================================================================
module bus_slave_sel
   import bus_slave_sel_pkg::*;
#(
   parameter int ADDR_W  = c_bus_addr_width,
   parameter int CH_NUM  = 4,
   parameter int SEL_MSB = 9,
   parameter int TIMEOUT = 16
) (
   input  wire           clk,
   input  wire           reset,
   bus_slave_sel_if.slave bus
);

   localparam int                SEL_W     = clog2(CH_NUM);
   localparam logic [CH_NUM-1:0] c_cs_idle = {CH_NUM{c_disable_}};

   bss_state_e        state_q,   state_d;
   logic [SEL_W-1:0]  idx_q,     idx_d;
   logic [CH_NUM-1:0] cs_q,      cs_d;
   logic              rdy_q,     rdy_d;
   logic              bus_err_q, bus_err_d;
   logic              busy_q,    busy_d;

   logic [SEL_W-1:0]  w_sel;
   logic [CH_NUM-1:0] w_cs_decode;
   logic              w_timer_clear;
   logic              w_timer_enable;
   logic              w_timer_expired;

   assign w_sel = bus.addr[SEL_MSB -: SEL_W];

   always_comb begin
      w_cs_decode        = c_cs_idle;
      w_cs_decode[w_sel] = c_enable_;
   end

   bus_wait_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_wait_timer (
      .clk     (clk),
      .reset   (reset),
      .clear   (w_timer_clear),
      .enable  (w_timer_enable),
      .expired (w_timer_expired)
   );

   // Priority inside ACCESS: abort, then ready, then timeout.
   always_comb begin
      state_d        = state_q;
      idx_d          = idx_q;
      cs_d           = cs_q;
      rdy_d          = c_disable_;
      bus_err_d      = 1'b0;
      busy_d         = busy_q;
      w_timer_clear  = 1'b0;
      w_timer_enable = 1'b0;

      case (state_q)
         BSS_IDLE: begin
            if (bus.as_ == c_enable_) begin
               idx_d         = w_sel;
               cs_d          = w_cs_decode;
               busy_d        = 1'b1;
               w_timer_clear = 1'b1;
               state_d       = BSS_ACCESS;
            end
         end

         BSS_ACCESS: begin
            if (bus.as_ == c_disable_) begin
               cs_d    = c_cs_idle;
               busy_d  = 1'b0;
               state_d = BSS_IDLE;
            end else if (bus.slv_rdy_[idx_q] == c_enable_) begin
               cs_d    = c_cs_idle;
               rdy_d   = c_enable_;
               state_d = BSS_DONE;
            end else if (w_timer_expired) begin
               cs_d      = c_cs_idle;
               rdy_d     = c_enable_;
               bus_err_d = 1'b1;
               state_d   = BSS_ERR;
            end else begin
               w_timer_enable = 1'b1;
            end
         end

         BSS_ERR: begin
            state_d = BSS_DONE;
         end

         BSS_DONE: begin
            if (bus.as_ == c_disable_) begin
               busy_d  = 1'b0;
               state_d = BSS_IDLE;
            end
         end

         default: begin
            cs_d    = c_cs_idle;
            busy_d  = 1'b0;
            state_d = BSS_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= BSS_IDLE;
         idx_q     <= '0;
         cs_q      <= c_cs_idle;
         rdy_q     <= c_disable_;
         bus_err_q <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         cs_q      <= cs_d;
         rdy_q     <= rdy_d;
         bus_err_q <= bus_err_d;
         busy_q    <= busy_d;
      end
   end

   assign bus.cs_     = cs_q;
   assign bus.rdy_    = rdy_q;
   assign bus.bus_err = bus_err_q;
   assign bus.busy    = busy_q;

endmodule : bus_slave_sel
`default_nettype wire

// File: doc/bus_slave_sel.md
Name: bus_slave_sel

Overview:
Registered, parametrised successor of the combinational chip-select decoder on the system bus.
- Decodes a master request address into one of CH_NUM active-low slave chip selects.
- Holds the select for the whole transfer and returns the selected slave's ready to the master.
- Terminates stalled transfers with a bus-error response after a programmable number of wait cycles.
- Sits between the bus master and the slave array, replacing the purely combinational decode.

Parameters:
ADDR_W, `BUS_ADDR_WIDTH, request address width.
CH_NUM, 4, number of slave channels; power of two, 2..16.
SEL_MSB, 9, MSB of the channel-select field; field is addr[SEL_MSB -: log2(CH_NUM)]; SEL_MSB >= log2(CH_NUM)-1.
TIMEOUT, 16, wait cycles allowed in ACCESS before error; 2..255.

Ports:
clk  in  1  bus clock; all state updates on rising edge.
reset  in  1  synchronous, active-high reset.
as_  in  1  master address strobe, active low; held low for the whole transfer.
addr  in  ADDR_W  request address; sampled only when IDLE and as_ low.
cs_  out  CH_NUM  per-slave chip select, active low (`Enable_), at most one bit low.
slv_rdy_  in  CH_NUM  per-slave ready, active low.
rdy_  out  1  ready to master, active low, single-cycle pulse.
bus_err  out  1  active high; pulses together with rdy_ on timeout.
busy  out  1  high in every state except IDLE.

Behaviour:
- All outputs are registered.
- Reset values: state IDLE, cs_ all `Disable_ (1), rdy_ 1, bus_err 0, busy 0, idx 0, wait counter 0.
- Reset has priority over every other event, including mid-transfer: cs_ releases the cycle after reset is sampled.

FSM states: IDLE, ACCESS, ERR, DONE.
- IDLE: on as_ low, latch idx = addr select field and clear the counter.
  - Next cycle: cs_[idx]=0, busy=1, state ACCESS. Latency from as_ sampled to cs_ low is 1 cycle.
  - addr bits outside the select field are ignored.
- ACCESS, selected ready (slv_rdy_[idx] sampled 0):
  - Next cycle: rdy_=0 for exactly one cycle, cs_ all 1, state DONE.
  - slv_rdy_ of non-selected channels is ignored.
- ACCESS, no ready: counter increments by 1 each cycle.
- ACCESS, timeout (counter == TIMEOUT-1 and no ready):
  - Next cycle: state ERR, cs_ all 1, rdy_=0 and bus_err=1 for one cycle.
- ACCESS, simultaneous ready and timeout: ready wins, normal completion, bus_err stays 0.
- ACCESS, abort (as_ sampled 1 before any ready):
  - Next cycle: cs_ all 1, state IDLE, no rdy_ pulse, no bus_err.
  - Abort has priority over ready and timeout in the same cycle.
- ERR: unconditional transition to DONE after one cycle.
- DONE: wait for as_ sampled 1, then IDLE.
  - A new request therefore needs at least one cycle with as_ high (no back-to-back without strobe release).
  - While in DONE: rdy_=1, bus_err=0, busy=1.
- Counter width: clog2(TIMEOUT). The counter saturates and never wraps.
- cs_ never glitches: changes only at the state transitions listed above.

Decomposition:
- Shared package/header (define.h): `Enable_/`Disable_, `BUS_ADDR_WIDTH, state encodings BSS_IDLE/ACCESS/ERR/DONE (2-bit), clog2 function.
- Natural sub-module: bus_wait_timer (clear, enable, parametrised TIMEOUT, outputs expired). All other logic stays in the top.

Test Plan:
- Reset/idle: assert reset 3 cycles, as_=1 -> cs_=4'b1111, rdy_=1, bus_err=0, busy=0 throughout.
- Decode all channels: for addr[9:8]=0..3 with slave ready 2 cycles after cs_ -> cs_ = 4'b1110 / 1101 / 1011 / 0111 respectively, from 1 cycle after as_ low; one rdy_ pulse per transfer.
- Ready filtering: slave 2 selected, slv_rdy_=4'b1110 (slave 0 only) held -> no rdy_; assert slv_rdy_[2] -> rdy_ pulses once, next cycle.
- Timeout: TIMEOUT=16, no slave ready -> cs_[idx] low exactly 16 cycles; then rdy_=0 with bus_err=1 for one cycle; returns to IDLE after as_ released.
- Ready/timeout race and abort:
  - Ready on the 16th wait cycle -> rdy_ pulse with bus_err=0.
  - as_ raised on wait cycle 3 -> cs_ all 1 next cycle, no rdy_.
- Reset mid-access: reset asserted on wait cycle 5 of channel 1 -> next cycle cs_=4'b1111, busy=0; a following request decodes normally.
